// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers for the AXIS FIFO pointer/flow-control sequencer.
package axis_fifo_pkg;

    // Pointers carry one wrap bit above the address bits so that full and empty can be told apart.
    function automatic int ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

    function automatic int count_width(input int els);
        return $clog2(els + 1);
    endfunction

endpackage

// File: rtl/axis_fifo_ctrl_if.sv
// Valid/ready handshake bundle for one AXIS stream direction.
interface axis_fifo_ctrl_if;
    logic tvalid;
    logic tready;

    modport master (output tvalid, input tready);
    modport slave  (input tvalid, output tready);
endinterface

// File: rtl/axis_fifo_valid_pipe.sv
// Valid-bit shadow of the memory's read pipeline; it applies the same load/clear rules as the data stages.
module axis_fifo_valid_pipe #(
    parameter int pipeline_output_p = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         flush_i,
    input  logic                         r_v_i,
    input  logic                         ready_i,
    output logic [pipeline_output_p-1:0] valid_o,
    output logic                         load1_o
);

    localparam int P = pipeline_output_p;

    logic [P:0]   load;
    logic [P-1:0] valid_q;
    logic [P-1:0] valid_d;

    assign load[0] = r_v_i;
    assign load[P] = ready_i;

    // An interior stage may load when the output drains or when the stage itself holds a bubble.
    generate
        for (genvar gi = 1; gi < P; gi++) begin : g_load
            assign load[gi] = ready_i | ~valid_q[gi];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign valid_d[gi] = flush_i   ? 1'b0 :
                                     load[gi]  ? 1'b1 :
                                     load[gi+1] ? 1'b0 : valid_q[gi];
            end else begin : g_rest
                assign valid_d[gi] = flush_i   ? 1'b0 :
                                     load[gi]  ? valid_q[gi-1] :
                                     load[gi+1] ? 1'b0 : valid_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign load1_o = load[1];

endmodule

// File: rtl/axis_fifo_ctrl.sv
// Pointer and flow-control sequencer for the AXIS FIFO; the paired memory supplies the data path.
module axis_fifo_ctrl
    import axis_fifo_pkg::*;
#(
    parameter int els_p             = 8,
    parameter int pipeline_output_p = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             flush_i,
    axis_fifo_ctrl_if.slave                  s_axis,
    axis_fifo_ctrl_if.master                 m_axis,
    output logic                             w_v_o,
    output logic [$clog2(els_p)-1:0]         w_addr_o,
    output logic                             r_v_o,
    output logic [$clog2(els_p)-1:0]         r_addr_o,
    output logic                             output_ready_o,
    output logic [pipeline_output_p-1:0]     valid_pipe_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic [count_width(els_p)-1:0]    count_o
);

    localparam int AW = $clog2(els_p);
    localparam int PW = ptr_width(els_p);
    localparam int CW = count_width(els_p);
    localparam int P  = pipeline_output_p;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [P-1:0]  valid;
    logic          load1;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign count_o = CW'(wptr_q - rptr_q);

    // Readiness comes only from registered pointers, so a read this cycle never frees a slot early.
    assign s_axis.tready = ~full_o;
    assign w_v_o         = s_axis.tvalid & ~full_o;
    assign w_addr_o      = wptr_q[AW-1:0];

    // Issue a read whenever stage 0 is empty or will hand its beat forward this cycle.
    assign r_v_o    = ~empty_o & (~valid[0] | load1);
    assign r_addr_o = rptr_q[AW-1:0];

    assign m_axis.tvalid  = valid[P-1];
    assign output_ready_o = m_axis.tready;
    assign valid_pipe_o   = valid;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (w_v_o) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (r_v_o) begin
                rptr_d = rptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    axis_fifo_valid_pipe #(
        .pipeline_output_p(P)
    ) u_valid_pipe (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .r_v_i     (r_v_o),
        .ready_i   (m_axis.tready),
        .valid_o   (valid),
        .load1_o   (load1)
    );

`ifndef SYNTHESIS
    a_not_full_and_empty : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(full_o && empty_o));
    a_tvalid_sticky : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (m_axis.tvalid && !m_axis.tready && !flush_i) |=> m_axis.tvalid);
`endif

endmodule
